// File: rtl/servant_mem_arbiter.sv
// Round-robin arbiter that puts the ibus, dbus and debug xbus Wishbone masters onto the single servant RAM port.
// A watchdog completes a transaction with zero data if the RAM never acknowledges it.
module servant_mem_arbiter #(
   parameter int unsigned aw      = 32,
   parameter int unsigned timeout = 255
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic [aw-1:0] i_wb_ibus_adr,
   input  logic          i_wb_ibus_cyc,
   output logic [31:0]   o_wb_ibus_rdt,
   output logic          o_wb_ibus_ack,
   input  logic [aw-1:0] i_wb_dbus_adr,
   input  logic [31:0]   i_wb_dbus_dat,
   input  logic [3:0]    i_wb_dbus_sel,
   input  logic          i_wb_dbus_we,
   input  logic          i_wb_dbus_cyc,
   output logic [31:0]   o_wb_dbus_rdt,
   output logic          o_wb_dbus_ack,
   input  logic [aw-1:0] i_wb_xbus_adr,
   input  logic [31:0]   i_wb_xbus_dat,
   input  logic [3:0]    i_wb_xbus_sel,
   input  logic          i_wb_xbus_we,
   input  logic          i_wb_xbus_cyc,
   output logic [31:0]   o_wb_xbus_rdt,
   output logic          o_wb_xbus_ack,
   output logic [aw-1:0] o_wb_mem_adr,
   output logic [31:0]   o_wb_mem_dat,
   output logic [3:0]    o_wb_mem_sel,
   output logic          o_wb_mem_we,
   output logic          o_wb_mem_cyc,
   input  logic [31:0]   i_wb_mem_rdt,
   input  logic          i_wb_mem_ack,
   output logic [1:0]    o_grant,
   output logic          o_timeout
);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [1:0] {M_NONE, M_IBUS, M_DBUS, M_XBUS} master_t;

   state_t      r_state, w_state_nxt;
   master_t     r_grant, w_grant_nxt;
   master_t     r_last, w_last_nxt;
   master_t     w_sel;
   logic [31:0] r_wdog, w_wdog_nxt;
   logic        r_timeout, w_timeout_nxt;
   logic        w_busy, w_cyc_g, w_ack, w_fire;
   logic [31:0] w_rdt;

   assign w_busy = (r_state == BUSY);

   // Rotating priority: the search starts at the master after the last one served.
   always_comb begin
      w_sel = M_NONE;
      case (r_last)
         M_IBUS: begin
            if (i_wb_dbus_cyc)      w_sel = M_DBUS;
            else if (i_wb_xbus_cyc) w_sel = M_XBUS;
            else if (i_wb_ibus_cyc) w_sel = M_IBUS;
         end
         M_DBUS: begin
            if (i_wb_xbus_cyc)      w_sel = M_XBUS;
            else if (i_wb_ibus_cyc) w_sel = M_IBUS;
            else if (i_wb_dbus_cyc) w_sel = M_DBUS;
         end
         default: begin
            if (i_wb_ibus_cyc)      w_sel = M_IBUS;
            else if (i_wb_dbus_cyc) w_sel = M_DBUS;
            else if (i_wb_xbus_cyc) w_sel = M_XBUS;
         end
      endcase
   end

   always_comb begin
      w_cyc_g      = 1'b0;
      o_wb_mem_adr = '0;
      o_wb_mem_dat = '0;
      o_wb_mem_sel = '0;
      o_wb_mem_we  = 1'b0;
      if (w_busy) begin
         case (r_grant)
            M_IBUS: begin
               w_cyc_g      = i_wb_ibus_cyc;
               o_wb_mem_adr = i_wb_ibus_adr;
               o_wb_mem_sel = 4'hf;
            end
            M_DBUS: begin
               w_cyc_g      = i_wb_dbus_cyc;
               o_wb_mem_adr = i_wb_dbus_adr;
               o_wb_mem_dat = i_wb_dbus_dat;
               o_wb_mem_sel = i_wb_dbus_sel;
               o_wb_mem_we  = i_wb_dbus_we;
            end
            M_XBUS: begin
               w_cyc_g      = i_wb_xbus_cyc;
               o_wb_mem_adr = i_wb_xbus_adr;
               o_wb_mem_dat = i_wb_xbus_dat;
               o_wb_mem_sel = i_wb_xbus_sel;
               o_wb_mem_we  = i_wb_xbus_we;
            end
            default: ;
         endcase
      end
   end

   // A real ack beats the watchdog; reset suppresses both so nothing is delivered mid-reset.
   assign w_ack  = w_busy && w_cyc_g && i_wb_mem_ack && !wb_rst;
   assign w_fire = w_busy && w_cyc_g && !i_wb_mem_ack && !wb_rst &&
                   (timeout != 0) && (r_wdog == timeout);

   assign w_rdt         = w_fire ? '0 : i_wb_mem_rdt;
   assign o_wb_ibus_rdt = w_rdt;
   assign o_wb_dbus_rdt = w_rdt;
   assign o_wb_xbus_rdt = w_rdt;
   assign o_wb_ibus_ack = (w_ack || w_fire) && (r_grant == M_IBUS);
   assign o_wb_dbus_ack = (w_ack || w_fire) && (r_grant == M_DBUS);
   assign o_wb_xbus_ack = (w_ack || w_fire) && (r_grant == M_XBUS);
   assign o_wb_mem_cyc  = w_busy && w_cyc_g && !w_fire;
   assign o_grant       = r_grant;
   assign o_timeout     = r_timeout;

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_last_nxt    = r_last;
      w_wdog_nxt    = r_wdog;
      w_timeout_nxt = r_timeout;
      case (r_state)
         IDLE: begin
            if (w_sel != M_NONE) begin
               w_state_nxt = BUSY;
               w_grant_nxt = w_sel;
               w_wdog_nxt  = '0;
            end
         end
         BUSY: begin
            // Completion, forced completion and abort all release the bus the same way.
            if (!w_cyc_g || w_ack || w_fire) begin
               w_state_nxt = IDLE;
               w_grant_nxt = M_NONE;
               w_last_nxt  = r_grant;
               if (w_fire) w_timeout_nxt = 1'b1;
            end else begin
               w_wdog_nxt = r_wdog + 32'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_state   <= IDLE;
         r_grant   <= M_NONE;
         r_last    <= M_XBUS;
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_last    <= w_last_nxt;
         r_wdog    <= w_wdog_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// Directed bench for servant_mem_arbiter: a simple RAM responder plus an ack scoreboard.
// Expected acks (master and data) are queued as requests are raised and popped as acks appear.
module tb_servant_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned TO = 8;

   logic          wb_clk = 1'b0;
   logic          wb_rst;
   logic [AW-1:0] i_adr, d_adr, x_adr;
   logic          i_cyc, d_cyc, x_cyc;
   logic [31:0]   d_dat, x_dat;
   logic [3:0]    d_sel, x_sel;
   logic          d_we, x_we;
   logic [31:0]   i_rdt, d_rdt, x_rdt;
   logic          i_ack, d_ack, x_ack;
   logic [AW-1:0] mem_adr;
   logic [31:0]   mem_dat;
   logic [3:0]    mem_sel;
   logic          mem_we, mem_cyc;
   logic [31:0]   ram_rdt;
   logic          ram_ack;
   logic          ram_en;
   logic [1:0]    grant;
   logic          tout;

   always #5 wb_clk = ~wb_clk;

   servant_mem_arbiter #(.aw(AW), .timeout(TO)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .i_wb_ibus_adr(i_adr), .i_wb_ibus_cyc(i_cyc),
      .o_wb_ibus_rdt(i_rdt), .o_wb_ibus_ack(i_ack),
      .i_wb_dbus_adr(d_adr), .i_wb_dbus_dat(d_dat), .i_wb_dbus_sel(d_sel),
      .i_wb_dbus_we(d_we), .i_wb_dbus_cyc(d_cyc),
      .o_wb_dbus_rdt(d_rdt), .o_wb_dbus_ack(d_ack),
      .i_wb_xbus_adr(x_adr), .i_wb_xbus_dat(x_dat), .i_wb_xbus_sel(x_sel),
      .i_wb_xbus_we(x_we), .i_wb_xbus_cyc(x_cyc),
      .o_wb_xbus_rdt(x_rdt), .o_wb_xbus_ack(x_ack),
      .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
      .o_wb_mem_we(mem_we), .o_wb_mem_cyc(mem_cyc),
      .i_wb_mem_rdt(ram_rdt), .i_wb_mem_ack(ram_ack),
      .o_grant(grant), .o_timeout(tout)
   );

   function automatic logic [31:0] ram_data(input logic [31:0] a);
      return (a >> 4) + 32'd3;
   endfunction

   // RAM acks one cycle after it sees cyc, when enabled.
   always @(posedge wb_clk) begin
      if (wb_rst) begin
         ram_ack <= 1'b0;
         ram_rdt <= '0;
      end else begin
         ram_ack <= mem_cyc && !ram_ack && ram_en;
         ram_rdt <= ram_data(mem_adr);
      end
   end

   typedef struct packed {
      logic [1:0]  m;
      logic [31:0] rdt;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          n_acks = 0;
   int          n_writes = 0;
   int          cyc_cnt;
   logic        hold = 1'b0;
   logic [2:0]  acked;
   logic [1:0]  s_grant;
   logic        s_mcyc, s_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rdt_of(input int unsigned m);
      case (m)
         1: return i_rdt;
         2: return d_rdt;
         default: return x_rdt;
      endcase
   endfunction

   task automatic push(input logic [1:0] m, input logic [31:0] rdt);
      exp_t e;
      e.m   = m;
      e.rdt = rdt;
      sb.push_back(e);
   endtask

   // Mid-cycle snapshot: scoreboard pops on acks, bus-content checks on live RAM cycles.
   task automatic monitor();
      exp_t e;
      acked   = {x_ack, d_ack, i_ack};
      s_grant = grant;
      s_mcyc  = mem_cyc;
      s_to    = tout;
      if ($countones(acked) > 1) chk("single_ack", 32'($countones(acked)), 32'd1);
      for (int unsigned m = 1; m <= 3; m++) begin
         if (acked[m-1]) begin
            n_acks++;
            chk("ack_owner", 32'(grant), 32'(m));
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'(m), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_master", 32'(m), 32'(e.m));
               chk("ack_rdt", rdt_of(m), e.rdt);
            end
         end
      end
      if (mem_cyc && grant == 2'd1) begin
         chk("ibus_we", 32'(mem_we), 32'd0);
         chk("ibus_sel", 32'(mem_sel), 32'hf);
         chk("ibus_dat", mem_dat, 32'd0);
      end
      if (mem_cyc && mem_we) begin
         n_writes++;
         chk("wr_grant", 32'(grant), 32'd2);
         chk("wr_adr", mem_adr, 32'h2000);
         chk("wr_dat", mem_dat, 32'hDEADBEEF);
         chk("wr_sel", 32'(mem_sel), 32'h3);
      end
   endtask

   task automatic step();
      @(negedge wb_clk);
      monitor();
      @(posedge wb_clk);
      #1;
      if (!hold) begin
         if (acked[0]) i_cyc = 1'b0;
         if (acked[1]) d_cyc = 1'b0;
         if (acked[2]) x_cyc = 1'b0;
      end
   endtask

   task automatic wait_acks(input int n, input int bound, output int cycles);
      int start;
      start  = n_acks;
      cycles = 0;
      while ((n_acks - start) < n && cycles < bound) begin
         step();
         cycles++;
      end
      if ((n_acks - start) < n) chk("wait_bound", 32'(n_acks - start), 32'(n));
   endtask

   task automatic do_reset();
      wb_rst = 1'b1;
      i_cyc  = 1'b0;
      d_cyc  = 1'b0;
      x_cyc  = 1'b0;
      step();
      step();
      wb_rst = 1'b0;
   endtask

   initial begin
      wb_rst = 1'b1;
      i_adr = '0; d_adr = '0; x_adr = '0;
      i_cyc = 1'b0; d_cyc = 1'b0; x_cyc = 1'b0;
      d_dat = '0; x_dat = '0; d_sel = 4'hf; x_sel = 4'hf; d_we = 1'b0; x_we = 1'b0;
      ram_en = 1'b1;
      acked = '0;
      @(posedge wb_clk);
      #1;
      do_reset();
      chk("rst_grant", 32'(s_grant), 32'd0);
      chk("rst_mem_cyc", 32'(s_mcyc), 32'd0);
      chk("rst_timeout", 32'(s_to), 32'd0);

      // Single ibus fetch after reset.
      i_adr = 32'h100;
      i_cyc = 1'b1;
      push(2'd1, 32'h13);
      wait_acks(1, 20, cyc_cnt);
      chk("ibus_latency", 32'(cyc_cnt - 1), 32'd2);
      step();
      step();

      // Three continuous requesters rotate 1,2,3,1,2,3.
      do_reset();
      i_adr = 32'h100; d_adr = 32'h200; x_adr = 32'h300;
      hold = 1'b1;
      i_cyc = 1'b1; d_cyc = 1'b1; x_cyc = 1'b1;
      for (int r = 0; r < 2; r++) begin
         push(2'd1, ram_data(32'h100));
         push(2'd2, ram_data(32'h200));
         push(2'd3, ram_data(32'h300));
      end
      wait_acks(6, 60, cyc_cnt);
      hold = 1'b0;
      i_cyc = 1'b0; d_cyc = 1'b0; x_cyc = 1'b0;
      chk("rr_cycles", 32'(cyc_cnt), 32'd18);
      step();
      step();

      // dbus write with a concurrent ibus request arriving one cycle later.
      d_adr = 32'h2000; d_dat = 32'hDEADBEEF; d_sel = 4'b0011; d_we = 1'b1; d_cyc = 1'b1;
      push(2'd2, ram_data(32'h2000));
      step();
      i_adr = 32'h104;
      i_cyc = 1'b1;
      push(2'd1, ram_data(32'h104));
      wait_acks(2, 30, cyc_cnt);
      chk("wr_cycles_seen", 32'(n_writes), 32'd2);
      d_we = 1'b0; d_sel = 4'hf;
      step();

      // dbus aborts two cycles into BUSY; pending xbus is served next.
      ram_en = 1'b0;
      d_adr = 32'h400;
      d_cyc = 1'b1;
      step();
      x_adr = 32'h500;
      x_cyc = 1'b1;
      step();
      step();
      d_cyc  = 1'b0;
      ram_en = 1'b1;
      push(2'd3, ram_data(32'h500));
      step();
      chk("abort_mem_cyc", 32'(s_mcyc), 32'd0);
      chk("abort_grant_busy", 32'(s_grant), 32'd2);
      step();
      chk("abort_idle", 32'(s_grant), 32'd0);
      step();
      chk("abort_next_grant", 32'(s_grant), 32'd3);
      wait_acks(1, 10, cyc_cnt);
      chk("abort_x_latency", 32'(cyc_cnt), 32'd1);
      step();

      // RAM never answers an xbus read: watchdog forces a zero-data ack.
      ram_en = 1'b0;
      x_adr = 32'h600;
      x_cyc = 1'b1;
      push(2'd3, 32'h0);
      wait_acks(1, 30, cyc_cnt);
      chk("wd_cycles", 32'(cyc_cnt), 32'd10);
      chk("wd_mem_cyc", 32'(s_mcyc), 32'd0);
      ram_en = 1'b1;
      step();
      chk("wd_flag_set", 32'(s_to), 32'd1);
      i_adr = 32'h108;
      i_cyc = 1'b1;
      push(2'd1, ram_data(32'h108));
      wait_acks(1, 10, cyc_cnt);
      chk("wd_after_ibus_lat", 32'(cyc_cnt), 32'd3);
      step();
      chk("wd_flag_sticky", 32'(s_to), 32'd1);

      // Reset in BUSY: no ack, bus released, ibus wins the first arbitration.
      d_adr = 32'h700;
      d_cyc = 1'b1;
      step();
      wb_rst = 1'b1;
      step();
      chk("rstbusy_grant", 32'(s_grant), 32'd2);
      wb_rst = 1'b0;
      i_adr = 32'h10C;
      i_cyc = 1'b1;
      push(2'd1, ram_data(32'h10C));
      push(2'd2, ram_data(32'h700));
      step();
      chk("rstbusy_mem_cyc", 32'(s_mcyc), 32'd0);
      chk("rstbusy_grant0", 32'(s_grant), 32'd0);
      chk("rstbusy_timeout", 32'(s_to), 32'd0);
      step();
      chk("rstbusy_first_grant", 32'(s_grant), 32'd1);
      wait_acks(2, 20, cyc_cnt);
      step();
      step();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
